// File: rtl/tmds_symbol_decoder.sv
// Receive-side TMDS channel decoder: 10-bit symbol -> 8-bit data or 2-bit control token.
// Two-stage pipeline with control-period lock tracking and coding-error detection.
module tmds_symbol_decoder #(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned ERR_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    input  logic       sym_valid,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked,
    output logic       err_pulse
);

    localparam logic [7:0] LOCK_CNT8 = 8'(LOCK_COUNT);
    localparam logic [7:0] ERR_LIM8  = 8'(ERR_LIMIT);

    typedef enum logic {
        S_HUNT,
        S_LOCKED
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ctl_cnt_q, ctl_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] ctl_inc, err_inc;

    logic [9:0] s1_sym_q, s1_sym_d;
    logic       s1_valid_q, s1_valid_d;
    logic       s1_tok_q, s1_tok_d;
    logic [1:0] s1_ctl_q, s1_ctl_d;

    logic [7:0] data_q, data_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       de_q, de_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic [7:0] q_bits;
    logic [7:0] dec;
    logic [3:0] n1;
    logic       prefer_xnor;
    logic       code_err;

    // Stage 1: capture the symbol and classify control tokens by exact match.
    always_comb begin
        s1_valid_d = sym_valid;
        s1_sym_d   = s1_sym_q;
        s1_tok_d   = s1_tok_q;
        s1_ctl_d   = s1_ctl_q;
        if (sym_valid) begin
            s1_sym_d = sym_in;
            s1_tok_d = 1'b1;
            case (sym_in)
                10'b1101010100: s1_ctl_d = 2'b00;
                10'b0010101011: s1_ctl_d = 2'b01;
                10'b0101010100: s1_ctl_d = 2'b10;
                10'b1010101011: s1_ctl_d = 2'b11;
                default:        s1_tok_d = 1'b0;
            endcase
        end
    end

    // Stage 2 decode: undo the optional inversion, then the XOR/XNOR chain.
    always_comb begin
        q_bits = s1_sym_q[9] ? ~s1_sym_q[7:0] : s1_sym_q[7:0];
        dec    = '0;
        dec[0] = q_bits[0];
        for (int unsigned i = 1; i < 8; i++) begin
            dec[i] = s1_sym_q[8] ? (q_bits[i] ^ q_bits[i-1]) : ~(q_bits[i] ^ q_bits[i-1]);
        end
        n1 = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, dec[i]};
        end
        prefer_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !dec[0]);
        code_err    = !s1_tok_q && ((!s1_sym_q[8]) != prefer_xnor);
    end

    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        de_d    = de_q;
        valid_d = s1_valid_q;
        err_d   = s1_valid_q && code_err;
        if (s1_valid_q) begin
            if (s1_tok_q) begin
                ctrl_d = s1_ctl_q;
                de_d   = 1'b0;
            end else begin
                data_d = dec;
                de_d   = 1'b1;
            end
        end
    end

    assign ctl_inc = (ctl_cnt_q == 8'hFF) ? ctl_cnt_q : ctl_cnt_q + 8'd1;
    assign err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Lock tracking advances at stage 2 so locked lines up with valid_out.
    always_comb begin
        state_d   = state_q;
        ctl_cnt_d = ctl_cnt_q;
        err_cnt_d = err_cnt_q;
        if (s1_valid_q) begin
            case (state_q)
                S_HUNT: begin
                    if (s1_tok_q) begin
                        if (ctl_inc >= LOCK_CNT8) begin
                            state_d   = S_LOCKED;
                            ctl_cnt_d = '0;
                            err_cnt_d = '0;
                        end else begin
                            ctl_cnt_d = ctl_inc;
                        end
                    end else begin
                        ctl_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (code_err) begin
                        if (err_inc >= ERR_LIM8) begin
                            state_d   = S_HUNT;
                            err_cnt_d = '0;
                            ctl_cnt_d = '0;
                        end else begin
                            err_cnt_d = err_inc;
                        end
                    end else begin
                        err_cnt_d = '0;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sym_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_tok_q   <= 1'b0;
            s1_ctl_q   <= '0;
            data_q     <= '0;
            ctrl_q     <= '0;
            de_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= S_HUNT;
            ctl_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_sym_q   <= s1_sym_d;
            s1_valid_q <= s1_valid_d;
            s1_tok_q   <= s1_tok_d;
            s1_ctl_q   <= s1_ctl_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            de_q       <= de_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            state_q    <= state_d;
            ctl_cnt_q  <= ctl_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign data_out  = data_q;
    assign ctrl_out  = ctrl_q;
    assign de_out    = de_q;
    assign valid_out = valid_q;
    assign err_pulse = err_q;
    assign locked    = (state_q == S_LOCKED);

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// Bench for tmds_symbol_decoder: encoder-inversion reference model checked every cycle,
// plus directed literal checks for reset, decode, lock, control map, errors and bubbles.
module tb_tmds_symbol_decoder;

    localparam int unsigned LOCK_COUNT = 8;
    localparam int unsigned ERR_LIMIT  = 4;
    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sym_in = '0;
    logic       sym_valid = 1'b0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out, valid_out, locked, err_pulse;

    always #5 clk = ~clk;

    tmds_symbol_decoder #(
        .LOCK_COUNT(LOCK_COUNT),
        .ERR_LIMIT (ERR_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sym_in   (sym_in),
        .sym_valid(sym_valid),
        .data_out (data_out),
        .ctrl_out (ctrl_out),
        .de_out   (de_out),
        .valid_out(valid_out),
        .locked   (locked),
        .err_pulse(err_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Encoder transition-minimisation stage for a byte in the given mode.
    function automatic logic [7:0] enc_qm(input logic [7:0] d, input logic use_xor);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        return qm;
    endfunction

    // Decode by searching for the byte the encoder would have turned into this symbol.
    task automatic m_decode(input logic [9:0] s, output logic [7:0] d, output bit e);
        logic [7:0] q;
        int ones;
        bit xnor_pref;
        q = s[9] ? ~s[7:0] : s[7:0];
        d = '0;
        for (int v = 0; v < 256; v++)
            if (enc_qm(8'(v), s[8]) == q) d = 8'(v);
        ones = $countones(d);
        xnor_pref = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        e = (s[8] == 1'b0) != xnor_pref;
    endtask

    function automatic int tok_code(input logic [9:0] s);
        case (s)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    typedef struct {
        logic [13:0] vec;
        bit          in_rst;
    } rec_t;

    rec_t hist[MAXC];
    int   cyc = 0;

    int         m_ctl = 0, m_err = 0;
    bit         m_lock = 0;
    logic [7:0] m_data = '0;
    logic [1:0] m_ctrl = '0;
    bit         m_de = 0;
    logic [7:0] md;
    bit         me, r_err;
    int         tc;

    always @(posedge clk) begin
        r_err = 0;
        if (rst) begin
            m_ctl = 0; m_err = 0; m_lock = 0;
            m_data = '0; m_ctrl = '0; m_de = 0;
        end else if (sym_valid) begin
            tc = tok_code(sym_in);
            if (tc >= 0) begin
                m_ctrl = 2'(tc);
                m_de = 0;
                me = 0;
            end else begin
                m_decode(sym_in, md, me);
                m_data = md;
                m_de = 1;
            end
            r_err = me;
            if (!m_lock) begin
                if (tc >= 0) begin
                    m_ctl = m_ctl + 1;
                    if (m_ctl >= LOCK_COUNT) begin m_lock = 1; m_ctl = 0; m_err = 0; end
                end else m_ctl = 0;
            end else begin
                if (me) begin
                    m_err = m_err + 1;
                    if (m_err >= ERR_LIMIT) begin m_lock = 0; m_err = 0; m_ctl = 0; end
                end else m_err = 0;
            end
        end
        if (cyc < MAXC) begin
            hist[cyc].in_rst = rst;
            hist[cyc].vec = rst ? 14'd0
                          : {(!rst && sym_valid), m_de, m_lock, r_err, m_ctrl, m_data};
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst || (cyc >= 1 && cyc - 1 < MAXC && hist[cyc-1].in_rst))
            chk("cycle_reset", int'({valid_out, de_out, locked, err_pulse, ctrl_out, data_out}), 0);
        else if (cyc >= 2 && cyc - 2 < MAXC)
            chk("cycle", int'({valid_out, de_out, locked, err_pulse, ctrl_out, data_out}),
                int'(hist[cyc-2].vec));
    end

    task automatic drive(input logic [9:0] s, input logic v);
        @(negedge clk);
        sym_in = s;
        sym_valid = v;
    endtask

    task automatic idle();
        drive(10'h000, 1'b0);
    endtask

    logic [9:0] dir_syms[6] = '{10'h1C3, 10'h2F0, 10'h05A, 10'h3FF, 10'h155, 10'h0F0};
    logic [7:0] pd;
    bit         pe;

    initial begin
        m_decode(10'h200, pd, pe);
        chk("pin_dec_200", int'(pd), 8'hFF);
        chk("pin_err_200", int'(pe), 0);
        m_decode(10'h100, pd, pe);
        chk("pin_dec_100", int'(pd), 8'h00);
        m_decode(10'h155, pd, pe);
        chk("pin_dec_155", int'(pd), 8'hFF);
        chk("pin_err_155", int'(pe), 1);
        chk("pin_tok_2AB", tok_code(10'h2AB), 3);

        // T1: reset with live input
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            sym_in = 10'($urandom);
            sym_valid = 1'b1;
        end
        chk("t1_rst_locked", int'(locked), 0);
        chk("t1_rst_valid", int'(valid_out), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        sym_valid = 1'b0;
        idle(); idle(); idle();
        chk("t1_rel_locked", int'(locked), 0);
        chk("t1_rel_valid", int'(valid_out), 0);

        // T2: data decode
        drive(10'h100, 1'b1);
        drive(10'h200, 1'b1);
        idle();
        chk("t2_data0", int'(data_out), 8'h00);
        chk("t2_de0", int'(de_out), 1);
        chk("t2_err0", int'(err_pulse), 0);
        chk("t2_valid0", int'(valid_out), 1);
        idle();
        chk("t2_data1", int'(data_out), 8'hFF);
        chk("t2_err1", int'(err_pulse), 0);
        foreach (dir_syms[i]) drive(dir_syms[i], 1'b1);
        idle(); idle();

        // T3: lock acquisition
        repeat (7) drive(10'h354, 1'b1);
        drive(10'h100, 1'b1);
        idle(); idle();
        chk("t3_no_lock", int'(locked), 0);
        repeat (8) drive(10'h354, 1'b1);
        idle(); idle();
        chk("t3_locked", int'(locked), 1);
        chk("t3_ctrl", int'(ctrl_out), 0);
        chk("t3_de", int'(de_out), 0);

        // T4: control map
        drive(10'h0AB, 1'b1);
        drive(10'h154, 1'b1);
        drive(10'h2AB, 1'b1);
        chk("t4_ctrl01", int'(ctrl_out), 1);
        chk("t4_de", int'(de_out), 0);
        idle();
        chk("t4_ctrl10", int'(ctrl_out), 2);
        idle();
        chk("t4_ctrl11", int'(ctrl_out), 3);
        chk("t4_data_held", int'(data_out), 8'h00);

        // T5: errors and loss of lock
        drive(10'h155, 1'b1);
        idle(); idle();
        chk("t5_err_pulse", int'(err_pulse), 1);
        chk("t5_still_locked", int'(locked), 1);
        drive(10'h155, 1'b1);
        drive(10'h155, 1'b1);
        drive(10'h100, 1'b1);
        repeat (3) drive(10'h155, 1'b1);
        idle(); idle();
        chk("t5_three_errs", int'(locked), 1);
        drive(10'h155, 1'b1);
        idle(); idle();
        chk("t5_unlock", int'(locked), 0);
        chk("t5_unlock_err", int'(err_pulse), 1);

        // T6: bubbles do not disturb token counting; async reset mid-lock
        for (int i = 0; i < 8; i++) begin
            drive(10'h354, 1'b1);
            drive(10'h100, 1'b0);
        end
        idle();
        chk("t6_locked", int'(locked), 1);
        chk("t6_valid", int'(valid_out), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_locked", int'(locked), 0);
        chk("t6_async_valid", int'(valid_out), 0);
        chk("t6_async_de", int'(de_out), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        drive(10'h200, 1'b1);
        idle(); idle();
        chk("t6_restart_data", int'(data_out), 8'hFF);
        chk("t6_restart_lock", int'(locked), 0);
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
